// File: rtl/adpll_loop_filter_if.sv
// Sample/control bundle between the phase detector, the PI loop filter and the DCO.
interface adpll_loop_filter_if #(
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned CTRL_W = 10
);
    logic                     err_valid;
    logic signed [ERR_W-1:0]  err;
    logic                     freeze;
    logic [CTRL_W-1:0]        ctrl;
    logic                     ctrl_valid;
    logic                     locked;
    logic                     sat;

    modport master (
        output err_valid, err, freeze,
        input  ctrl, ctrl_valid, locked, sat
    );

    modport slave (
        input  err_valid, err, freeze,
        output ctrl, ctrl_valid, locked, sat
    );
endinterface

// File: rtl/adpll_loop_filter.sv
// ADPLL proportional-integral loop filter: signed phase error in, clamped unsigned
// DCO tuning word out, with lock detection and a saturation flag.
module adpll_loop_filter #(
    parameter int unsigned ERR_W     = 8,
    parameter int unsigned CTRL_W    = 10,
    parameter int unsigned KP_SHIFT  = 2,
    parameter int unsigned KI_SHIFT  = 5,
    parameter int unsigned CTRL_INIT = 512,
    parameter int unsigned LOCK_TH   = 2,
    parameter int unsigned LOCK_CNT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    adpll_loop_filter_if.slave   lf
);
    localparam int unsigned ACC_W  = CTRL_W + KI_SHIFT + 1;
    localparam int unsigned SUM_W  = ACC_W + ERR_W + KP_SHIFT + 2;
    localparam int unsigned LCNT_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned CTRL_MAX_I = (2 ** CTRL_W) - 1;

    // Accumulator bounds, expressed in the one-bit-wider sum width
    localparam logic signed [ACC_W:0] ACC_HI = {3'b000, {(ACC_W-2){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_LO = {3'b111, {(ACC_W-2){1'b0}}};
    localparam logic signed [SUM_W-1:0] CTRL_MAX = SUM_W'(CTRL_MAX_I);

    logic signed [ACC_W-1:0] acc;
    logic signed [ERR_W-1:0] err_r;
    logic                    v1;
    logic [LCNT_W-1:0]       lcnt;

    logic                    accept_c;
    logic signed [ACC_W:0]   acc_sum_c;
    logic signed [ACC_W-1:0] acc_nxt_c;
    logic [ERR_W:0]          err_ext_c;
    logic [ERR_W:0]          err_mag_c;
    logic [LCNT_W-1:0]       lcnt_nxt_c;
    logic signed [SUM_W-1:0] sum_c;
    logic [CTRL_W-1:0]       ctrl_nxt_c;
    logic                    sat_nxt_c;

    assign accept_c = lf.err_valid & ~lf.freeze;

    // Integrator update with clamping; the extra sum bit keeps the add from wrapping
    always_comb begin
        acc_sum_c = (ACC_W+1)'(acc) + (ACC_W+1)'($signed(lf.err));
        acc_nxt_c = acc_sum_c[ACC_W-1:0];
        if (acc_sum_c > ACC_HI) begin
            acc_nxt_c = ACC_HI[ACC_W-1:0];
        end else if (acc_sum_c < ACC_LO) begin
            acc_nxt_c = ACC_LO[ACC_W-1:0];
        end
    end

    // Lock counter; magnitude taken one bit wider so the most negative error is out of lock
    always_comb begin
        err_ext_c  = (ERR_W+1)'($signed(lf.err));
        err_mag_c  = err_ext_c[ERR_W] ? (ERR_W+1)'(-err_ext_c) : err_ext_c;
        lcnt_nxt_c = '0;
        if (err_mag_c <= (ERR_W+1)'(LOCK_TH)) begin
            lcnt_nxt_c = (lcnt == LCNT_W'(LOCK_CNT)) ? lcnt : lcnt + LCNT_W'(1);
        end
    end

    // Stage 2: centre + floored integral + proportional, clamped to the DCO range
    always_comb begin
        sum_c = SUM_W'(CTRL_INIT)
              + SUM_W'(acc >>> KI_SHIFT)
              + (SUM_W'(err_r) <<< KP_SHIFT);
        ctrl_nxt_c = sum_c[CTRL_W-1:0];
        sat_nxt_c  = 1'b0;
        if (sum_c < 0) begin
            ctrl_nxt_c = '0;
            sat_nxt_c  = 1'b1;
        end else if (sum_c > CTRL_MAX) begin
            ctrl_nxt_c = CTRL_W'(CTRL_MAX_I);
            sat_nxt_c  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            err_r         <= '0;
            v1            <= 1'b0;
            lcnt          <= '0;
            lf.locked     <= 1'b0;
            lf.ctrl       <= CTRL_W'(CTRL_INIT);
            lf.ctrl_valid <= 1'b0;
            lf.sat        <= 1'b0;
        end else begin
            v1            <= accept_c;
            lf.ctrl_valid <= v1;
            if (accept_c) begin
                acc       <= acc_nxt_c;
                err_r     <= lf.err;
                lcnt      <= lcnt_nxt_c;
                lf.locked <= (lcnt_nxt_c == LCNT_W'(LOCK_CNT));
            end
            if (v1) begin
                lf.ctrl <= ctrl_nxt_c;
                lf.sat  <= sat_nxt_c;
            end
        end
    end
endmodule

// File: doc/adpll_loop_filter.md
# adpll_loop_filter

Digital proportional-integral loop filter for the ADPLL. Sits between the phase detector, which produces signed phase-error samples, and the DCO, which consumes the unsigned tuning word. Also provides a lock indicator and a saturation flag for the top-level status outputs.

## Interface

Parameters:
- ERR_W, 8, width of the signed phase-error input.
- CTRL_W, 10, width of the unsigned DCO control word.
- KP_SHIFT, 2, proportional gain as a left shift (Kp = 2^KP_SHIFT).
- KI_SHIFT, 5, integral gain as a right shift of the accumulator (Ki = 2^-KI_SHIFT).
- CTRL_INIT, 512, control word at reset and the filter's zero-error centre.
- LOCK_TH, 2, maximum |err| counted as "in lock".
- LOCK_CNT, 16, consecutive in-lock samples required to assert locked.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- err_valid  in  1  one-cycle strobe; err is valid this cycle.
- err  in  ERR_W  signed two's-complement phase error.
- freeze  in  1  when high, incoming samples are ignored entirely.
- ctrl  out  CTRL_W  DCO tuning word, registered.
- ctrl_valid  out  1  one-cycle pulse when ctrl updates.
- locked  out  1  lock indicator, registered.
- sat  out  1  ctrl was clamped on its last update.

## Operation

- Accepted sample: err_valid=1 and freeze=0 in the same cycle. All other cycles are no-ops for every register except the pipeline valid bits, which clear.
- Accumulator acc: signed, CTRL_W+KI_SHIFT+1 bits, reset 0.
  - On an accepted sample: acc <= clamp(acc + sext(err)) to [-2^(CTRL_W+KI_SHIFT-1), 2^(CTRL_W+KI_SHIFT-1)-1].
  - The sum is formed one bit wider, so it cannot wrap before the clamp.
- Stage 1 (cycle after acceptance): acc is updated and err is captured into err_r; valid bit v1=1.
- Stage 2 (when v1=1):
  - Form sum = CTRL_INIT + (acc >>> KI_SHIFT) + (err_r <<< KP_SHIFT) in a width with no overflow.
  - The >>> is arithmetic, so it floors toward -infinity.
  - Clamp sum to [0, 2^CTRL_W-1] and register it into ctrl.
  - Set ctrl_valid=1 for that cycle; sat=1 if the clamp engaged, else 0.
- ctrl, and sat when no update occurs, hold their value.
- Lock detector: counter lcnt, 0..LOCK_CNT, saturating, reset 0. Updated only on accepted samples.
  - If |err| <= LOCK_TH: lcnt <= min(lcnt+1, LOCK_CNT). Otherwise lcnt <= 0.
  - |err| is evaluated without overflow; err = -2^(ERR_W-1) is out of lock.
- locked = (lcnt == LOCK_CNT), registered alongside lcnt.
- freeze does not clear acc, lcnt or locked; it only suppresses samples.

## Timing

- Reset values:
  - Outputs: ctrl=CTRL_INIT, ctrl_valid=0, locked=0, sat=0.
  - Internal: acc=0, lcnt=0, err_r=0, v1=0.
- Latency: a sample accepted at edge N produces ctrl and ctrl_valid at edge N+2.
- Throughput: one sample per cycle. Back-to-back err_valid yields back-to-back ctrl_valid with no bubbles.
- locked responds at edge N+1 relative to the accepting edge N. This covers both rise on the LOCK_CNT-th in-lock sample and fall on the first out-of-lock sample.
- Reset asserted mid-stream:
  - At the next edge all registers take reset values and any in-flight sample is discarded.
  - No ctrl_valid occurs for samples accepted before or during reset.
- err_valid with freeze=1 in the same cycle: the sample is dropped and no ctrl_valid follows.
- No handshake back-pressure: the DCO must accept ctrl whenever ctrl_valid pulses.

## Test plan

All scenarios use default parameters.

- Reset: hold rst 2 cycles, then release -> ctrl=512, ctrl_valid=0, locked=0, sat=0, and they stay so with err_valid=0.
- Single sample: one err=+4 -> two edges later ctrl=528 (acc=4, integral term 0, proportional term 16), ctrl_valid high exactly one cycle, sat=0.
- Integrator: 32 consecutive err=+1 -> 32 ctrl_valid pulses; final ctrl=517; then one err=-1 -> ctrl=512-4+0 (acc=31 gives integral 0) = 508.
- Saturation:
  - Stream err=+127 -> ctrl ramps to 1023 with sat=1 on clamped updates.
  - Then stream err=-128 -> ctrl reaches 0 with sat=1.
  - acc never wraps; sign of acc stays consistent with the stream.
- Lock:
  - 16 samples cycling through -2,-1,0,1,2 -> locked=1 one edge after the 16th sample.
  - Then err=3 -> locked=0 next edge.
  - 15 in-lock samples followed by err=-128 -> locked never rises.
- Freeze and reset:
  - freeze=1 with err_valid and err=50 -> no ctrl_valid, ctrl unchanged, and a following unfrozen err=0 shows acc unchanged.
  - rst asserted the cycle after a sample -> no ctrl_valid, and ctrl=512.
